timer_arbiter: RTL and testbench
================================

Name: timer_arbiter

Overview:
- Shares a single programmable timeout counter between NREQ requesters, arbitrated round-robin.
- Each requester asks for a timeout of its own length; the grantee receives a one-cycle done pulse when its timeout expires.
- Sits between lab control FSMs and a counter10k-style timeout resource, replacing per-FSM private timers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CNT_W, 16, width of the counter and of each limit field.

Ports:
- tick  in  1  system clock; all logic on posedge tick.
- reset  in  1  synchronous, active-low reset: reset==0 at a tick edge resets the block.
- req  in  NREQ  level request per requester; held high until done, or until dropped under abort.
- limit  in  NREQ*CNT_W  per-requester timeout length; field i is limit[i*CNT_W +: CNT_W]; sampled only in LOAD.
- grant  out  NREQ  one-hot; the current owner of the timer.
- done  out  NREQ  one-hot, one-cycle pulse on the owner's bit at expiry.
- busy  out  1  high in every state except IDLE.
- count  out  CNT_W  live counter value, for debug.

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE.
  - grant=0, done=0, busy=0, count=0.
  - Internal pointer ptr=NREQ-1, so req[0] has first priority after reset.
  - Reset overrides every other event, including mid-COUNT; an aborted timeout produces no done.
- States: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - If req!=0, pick the first set bit searching ptr+1, ptr+2, ... with wrap-around.
  - Latch the pick into idx and go to LOAD. Otherwise stay in IDLE.
- LOAD:
  - grant[idx]=1, busy=1, count<=0.
  - Latch lim<=limit field idx. Go to COUNT.
- COUNT:
  - If count==lim, go to DONE; else count<=count+1.
  - count never exceeds lim, so no wrap. lim=2^CNT_W-1 is legal.
- DONE:
  - done[idx]=1 for exactly this cycle; grant still held.
  - ptr<=idx. Go to IDLE.
- Latency: the grant rising edge occurs 1 edge after req is seen in IDLE. done rises exactly lim+2 edges after grant rises. lim=0 is legal: done rises 2 edges after grant.
- Back-to-back: there is always one IDLE cycle between DONE and the next LOAD. A new grant and a done pulse never share a cycle.
- Requests that change while not in IDLE are ignored until the next IDLE arbitration. limit changes after LOAD have no effect.
- A requester that keeps req high after its done is re-granted only when no other requester is pending (round-robin fairness).
- grant and done are registered outputs; count is the counter register itself.

Optional Feature:
- Macro: TIMER_ARB_ABORT_EN.
- Defined: in LOAD or COUNT, if req[idx]==0, the next edge goes to IDLE.
  - grant=0, count=0, no done pulse.
  - ptr<=idx, so the aborting requester loses priority.
- Undefined: req is not monitored after arbitration; a granted timeout always runs to DONE.

Decomposition:
- Package timer_arb_pkg holds:
  - state encoding constants (IDLE=2'd0, LOAD=2'd1, COUNT=2'd2, DONE=2'd3);
  - the default CNT_W;
  - the default NREQ.
- One natural sub-module: rr_pick. It is combinational, with inputs req and ptr, and outputs a valid flag plus the picked index. It is reused by other arbiters in the lab set.

Test Plan:
- Reset: hold reset=0 for 3 edges with req=4'hF, limit all 16'h000A -> grant=0, done=0, busy=0, count=0 throughout. After release, the first grant is 4'b0001.
- Single request: req=4'b0010, limit[1]=16'd10 -> grant=4'b0010 one edge later; count runs 0..10; done=4'b0010 for exactly 1 cycle, 12 edges after grant rises; then busy=0.
- Round-robin: req=4'hF held continuously, all limits 16'd3 -> grant sequence 0001, 0010, 0100, 1000, 0001. Each done pulse appears 5 edges after its grant, followed by one IDLE cycle.
- Boundary: limit[2]=0, req=4'b0100 -> done[2] 2 edges after grant. With limit[3]=16'hFFFF, count reaches 16'hFFFF with no wrap, then DONE.
- Reset mid-operation: assert reset=0 while in COUNT at count=5 -> next edge grant=0, count=0, and no done ever follows. After release with req=4'b1010, the first grant goes to req1.
- Abort, TIMER_ARB_ABORT_EN defined: drop req[2] at count=4 -> next edge grant=0, busy=0, no done. With the macro undefined, the same stimulus still yields done[2] on schedule.

Source files
------------

// File: rtl/timer_arb_pkg.sv
// Shared types and defaults for the round-robin timeout arbiter.
package timer_arb_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr, wrapping.
module rr_pick
    import timer_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int j;
        j     = 0;
        valid = 1'b0;
        idx   = '0;
        // Walk from the farthest slot back so the nearest one wins.
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// One timeout counter shared round-robin between NREQ requesters.
// Define TIMER_ARB_ABORT_EN to cancel a timeout when its requester drops req.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                  tick,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CNT_W-1:0] limit,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [CNT_W-1:0]      count
);

    localparam int IDX_W = $clog2(NREQ);

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [IDX_W-1:0]   ptr, ptr_n;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic [CNT_W-1:0]   lim, lim_n;
    logic [CNT_W-1:0]   count_n;
    logic [NREQ-1:0]    grant_n, done_n;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge tick) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            ptr   <= IDX_W'(NREQ - 1);
            lim   <= '0;
            count <= '0;
            grant <= '0;
            done  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            ptr   <= ptr_n;
            lim   <= lim_n;
            count <= count_n;
            grant <= grant_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        ptr_n   = ptr;
        lim_n   = lim;
        count_n = count;
        grant_n = grant;
        done_n  = '0;
        unique case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n           = LOAD;
                    idx_n             = pick_idx;
                    grant_n           = '0;
                    grant_n[pick_idx] = 1'b1;
                end
            end
            LOAD: begin
                count_n = '0;
                lim_n   = limit[int'(idx)*CNT_W +: CNT_W];
                state_n = COUNT;
            end
            COUNT: begin
                if (count == lim) begin
                    state_n     = DONE;
                    done_n[idx] = 1'b1;
                end else begin
                    count_n = count + CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
                ptr_n   = idx;
            end
        endcase
`ifdef TIMER_ARB_ABORT_EN
        // Owner gave up: release the timer and hand priority onward.
        if ((state == LOAD || state == COUNT) && !req[idx]) begin
            state_n = IDLE;
            grant_n = '0;
            done_n  = '0;
            count_n = '0;
            ptr_n   = idx;
        end
`endif
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: event-level model predicts grant/done edges.
module tb_timer_arbiter;

    localparam int INF = 32'h3fffffff;

    typedef struct {
        int who;
        int at;
        int lim;
    } ev_t;

    logic        tick  = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req   = '0;
    logic [63:0] limit = '0;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [15:0] count;

    timer_arbiter dut (
        .tick  (tick),
        .reset (reset),
        .req   (req),
        .limit (limit),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    always #5 tick = ~tick;

    int edge_n = 0;
    always @(posedge tick) edge_n <= edge_n + 1;

    int   n_checks = 0;
    int   n_errs   = 0;
    ev_t  gq[$];
    ev_t  dq[$];
    int   m_ptr    = 3;
    int   m_owner  = 0;
    int   arb_ok   = INF;
    int   load_e   = INF;
    int   act_lo   = INF;
    int   act_hi   = INF;
    bit   pend     = 1'b0;
    bit   mon_en   = 1'b0;
    logic [3:0] prev_grant = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at edge %0d",
                     name, act, exp, edge_n);
        end
    endtask

    function automatic int rr(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Event-level reference: who gets the timer, and on which edges.
    task automatic model(input int e, input logic [3:0] r,
                         input logic [63:0] L, input logic rst);
        if (!rst) begin
            gq.delete();
            dq.delete();
            m_ptr  = 3;
            arb_ok = e + 1;
            pend   = 1'b0;
            act_lo = INF;
            act_hi = INF;
            return;
        end
`ifdef TIMER_ARB_ABORT_EN
        if (e >= act_lo && e <= act_hi && !r[m_owner]) begin
            if (!pend && dq.size() > 0) void'(dq.pop_back());
            pend   = 1'b0;
            arb_ok = e + 1;
            act_lo = INF;
            act_hi = INF;
            return;
        end
`endif
        if (pend && e == load_e) begin
            int lim;
            lim = int'(L[m_owner*16 +: 16]);
            dq.push_back('{m_owner, e + lim + 1, lim});
            arb_ok = e + lim + 3;
            act_hi = e + lim + 1;
            pend   = 1'b0;
        end else if (!pend && e >= arb_ok && r != 4'h0) begin
            m_owner = rr(r, m_ptr);
            m_ptr   = m_owner;
            gq.push_back('{m_owner, e, 0});
            load_e  = e + 1;
            pend    = 1'b1;
            arb_ok  = INF;
            act_lo  = e + 1;
            act_hi  = INF;
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [63:0] L,
                        input logic rst = 1'b1, input bit drop = 1'b0);
        logic [3:0] rv;
        rv = r;
        if (!drop && edge_n + 1 >= act_lo && edge_n + 1 <= act_hi)
            rv[m_owner] = 1'b1;
        req   = rv;
        limit = L;
        reset = rst;
        @(posedge tick);
        #1;
        model(edge_n, rv, L, rst);
    endtask

    task automatic run_idle();
        int n;
        n = 0;
        while (!(!pend && edge_n + 1 >= arb_ok && gq.size() == 0 &&
                 dq.size() == 0) && n < 70000) begin
            step(4'h0, limit);
            n++;
        end
        chk("idle_reached", 32'(n < 70000), 32'h1);
        chk("idle_busy", 32'(busy), 32'h0);
    endtask

    always @(negedge tick) begin
        if (mon_en) begin
            if (grant !== 4'h0 && prev_grant === 4'h0) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", 32'(grant), 32'h0);
                end else begin
                    ev_t x;
                    x = gq.pop_front();
                    chk("grant_who", 32'(grant), 32'(1) << x.who);
                    chk("grant_edge", 32'(edge_n), 32'(x.at));
                end
            end
            if (done !== 4'h0) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'h0);
                end else begin
                    ev_t x;
                    x = dq.pop_front();
                    chk("done_who", 32'(done), 32'(1) << x.who);
                    chk("done_edge", 32'(edge_n), 32'(x.at));
                    chk("done_count", 32'(count), 32'(x.lim));
                    chk("done_grant", 32'(grant), 32'(1) << x.who);
                end
            end
            prev_grant = grant;
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            step(4'hF, {4{16'h000A}}, 1'b0);
            mon_en = 1'b1;
            chk("rst_grant", 32'(grant), 32'h0);
            chk("rst_done", 32'(done), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_count", 32'(count), 32'h0);
        end

        step(4'hF, {4{16'd3}});
        chk("first_grant", 32'(grant), 32'h1);
        for (int i = 0; i < 29; i++) step(4'hF, {4{16'd3}});
        run_idle();

        step(4'b0010, {16'd0, 16'd0, 16'd10, 16'd0});
        chk("single_grant", 32'(grant), 32'h2);
        run_idle();

        step(4'b0100, {16'd0, 16'd0, 16'd0, 16'd9});
        run_idle();

        for (int i = 0; i < 70000 && count !== 16'hFFFF; i++)
            step(4'b1000, {16'hFFFF, 48'd0});
        chk("cnt_max", 32'(count), 32'hFFFF);
        run_idle();

        repeat (7) step(4'b1000, {16'd20, 48'd0});
        chk("mid_count", 32'(count), 32'd5);
        step(4'b1000, {16'd20, 48'd0}, 1'b0);
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_count", 32'(count), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        step(4'b1010, {4{16'd2}});
        chk("post_rst_grant", 32'(grant), 32'h2);
        run_idle();

        repeat (6) step(4'b0100, {16'd0, 16'd10, 32'd0});
        chk("abort_pre_count", 32'(count), 32'd4);
        step(4'b0000, {16'd0, 16'd10, 32'd0}, 1'b1, 1'b1);
`ifdef TIMER_ARB_ABORT_EN
        chk("abort_grant", 32'(grant), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_count", 32'(count), 32'h0);
`else
        chk("noabort_grant", 32'(grant), 32'h4);
        chk("noabort_count", 32'(count), 32'd5);
`endif
        run_idle();

        for (int i = 0; i < 3000; i++) begin
            logic [63:0] lv;
            logic        rs;
            lv = {16'($urandom_range(0, 5)), 16'($urandom_range(0, 5)),
                  16'($urandom_range(0, 5)), 16'($urandom_range(0, 5))};
            rs = ($urandom_range(0, 63) != 0);
            step(4'($urandom_range(0, 15)), lv, rs);
        end
        run_idle();
        chk("gq_empty", 32'(gq.size()), 32'h0);
        chk("dq_empty", 32'(dq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
